// File: rtl/ct_butterfly_stage.sv
// Cooley-Tukey butterfly back-end for the q = 3329 NTT datapath.
// The even coefficient u is delayed to line up with the product t coming out
// of the Plantard multiplier. The block then produces x = (u + t) mod q and
// y = (u - t) mod q, and counts butterflies so it can flag the end of a layer.
module ct_butterfly_stage #(
  parameter int                    data_width = 12,
  parameter logic [data_width-1:0] q          = 12'd3329,
  parameter int                    MUL_LAT    = 4,
  parameter int                    N_BFLY     = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [data_width-1:0] u_in,
  input  logic [data_width-1:0] t_in,
  output logic [data_width-1:0] x_out,
  output logic [data_width-1:0] y_out,
  output logic                  out_valid,
  output logic                  layer_done,
  output logic                  busy
);

  localparam int CNT_W = $clog2(N_BFLY);

  logic [MUL_LAT-1:0]    dl_v;
  logic [data_width-1:0] dl_u [MUL_LAT];
  logic                  v_d;
  logic [data_width-1:0] u_d;
  logic [data_width:0]   sum;
  logic [data_width-1:0] x_nxt;
  logic [data_width-1:0] y_nxt;
  logic [CNT_W-1:0]      bfly_cnt;

  // Delay line for {valid, u}, one stage per multiplier pipeline stage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dl_v <= '0;
      for (int i = 0; i < MUL_LAT; i++) dl_u[i] <= '0;
    end else begin
      dl_v[0] <= in_valid;
      dl_u[0] <= u_in;
      for (int i = 1; i < MUL_LAT; i++) begin
        dl_v[i] <= dl_v[i-1];
        dl_u[i] <= dl_u[i-1];
      end
    end
  end

  assign v_d = dl_v[MUL_LAT-1];
  assign u_d = dl_u[MUL_LAT-1];

  // Modular add/sub. The difference wraps modulo 2^data_width and adding q
  // back lands in [0, q) whenever u < t, so no explicit sign bit is needed.
  always_comb begin
    sum   = {1'b0, u_d} + {1'b0, t_in};
    x_nxt = (sum >= {1'b0, q}) ? data_width'(sum - {1'b0, q}) : sum[data_width-1:0];
    y_nxt = (u_d >= t_in) ? (u_d - t_in) : (u_d - t_in + q);
  end

  // Output registers and per-layer butterfly counter; x/y hold on idle cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      x_out      <= '0;
      y_out      <= '0;
      out_valid  <= 1'b0;
      layer_done <= 1'b0;
      bfly_cnt   <= '0;
    end else begin
      out_valid  <= v_d;
      layer_done <= v_d && (bfly_cnt == CNT_W'(N_BFLY - 1));
      if (v_d) begin
        x_out    <= x_nxt;
        y_out    <= y_nxt;
        bfly_cnt <= bfly_cnt + CNT_W'(1);
      end
    end
  end

  // Busy while any accepted beat has not yet been presented on the outputs.
  assign busy = (|dl_v) | out_valid;

endmodule

// File: doc/ct_butterfly_stage.md
Name: ct_butterfly_stage

Overview:
Cooley-Tukey butterfly back-end for the Kyber-domain (q = 3329) NTT datapath. It sits directly downstream of the constant Plantard multiplier: the multiplier receives the odd coefficient, and this block receives the even coefficient in the same cycle. The block delays the even coefficient to match the multiplier latency, then combines it with the product t to produce x = (u + t) mod q and y = (u - t) mod q. It also counts butterflies per NTT layer and flags layer completion.

Parameters:
data_width, 12, coefficient width
q, 12'd3329, modulus
MUL_LAT, 4, cycles from multiplier operand input to its registered product output
N_BFLY, 256, butterflies per layer; must be a power of two, >= 2

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-low reset
in_valid  input  1  u_in valid; matching operand presented to multiplier this cycle
u_in  input  data_width  even coefficient u, canonical (< q)
t_in  input  data_width  multiplier product (C_out), canonical; sampled MUL_LAT cycles after in_valid
x_out  output  data_width  (u + t) mod q
y_out  output  data_width  (u - t) mod q
out_valid  output  1  x_out/y_out valid this cycle
layer_done  output  1  one-cycle pulse coincident with the N_BFLY-th out_valid of a layer
busy  output  1  high while any accepted beat has not yet produced out_valid

Behaviour:
- All state updates on rising clk. When rst is low at an edge, all state clears: delay-line valids = 0, delay-line data = 0, x_out = 0, y_out = 0, out_valid = 0, layer_done = 0, counter = 0, busy = 0.
- Reset mid-operation discards every in-flight beat. No output appears for beats accepted before reset.
- No backpressure. The pipeline advances every cycle, and in_valid may be high on every cycle.
- Delay line: MUL_LAT register stages carrying {in_valid, u_in}. Tap d = stage MUL_LAT output, so u_d and v_d are aligned with t_in.
- Combine, when v_d = 1:
  - s = u_d + t_in, data_width+1 bits; x = s - q if s >= q, else s.
  - d = u_d - t_in, signed; y = d + q if d < 0, else d.
  - Results are registered: x_out, y_out, out_valid = 1 on the next edge.
- Latency: in_valid at edge k gives out_valid at edge k + MUL_LAT + 1. Throughput is 1 butterfly per cycle.
- When v_d = 0: out_valid goes to 0 and x_out/y_out hold their previous values. t_in is ignored.
- Counter: log2(N_BFLY) bits, increments on each out_valid cycle.
  - layer_done = 1 in the same cycle as the out_valid whose pre-increment count is N_BFLY-1.
  - The counter then wraps to 0. Back-to-back layers need no idle cycle.
- busy = OR of all delay-line valid bits and out_valid (combinational from registers).
- Inputs >= q are outside the contract. The bench must not drive them, and the output for them is unspecified.
- Outputs are always canonical (< q) for canonical inputs.

Test Plan:
1. Reset, then single beat u=100, t=50 -> out_valid exactly MUL_LAT+1 = 5 cycles later; x_out=150, y_out=50; busy high for those 5 cycles, then low.
2. Wrap cases: (u=3000, t=1000) -> x=671, y=2000; (u=10, t=20) -> x=30, y=3319; (u=3328, t=3328) -> x=3327, y=0; (u=0, t=0) -> x=0, y=0.
3. 256 back-to-back beats with random canonical u/t, compared against a reference model -> 256 consecutive out_valid cycles, all results match, layer_done pulses only with beat 256.
4. Two layers of 256 beats separated by a 3-cycle idle gap -> layer_done pulses exactly twice; x_out/y_out hold their values during the gap with out_valid=0.
5. Pulse rst low for 1 cycle while 3 beats are in flight -> none of the 3 appear; all outputs, busy, and the counter read 0. The next beat after reset produces a correct result, and a layer then needs a full 256 outputs before layer_done.
6. Stuff t_in with 0xFFF on cycles where v_d=0 -> no effect on outputs or the counter.
